// File: rtl/mpu_cfg_ctrl.sv
// MPU trigger configuration controller: host-loaded shadow weights/thresholds,
// frame-synchronous commit into the active bank, and post-update trigger masking.
module mpu_cfg_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_wr,
    input  logic          cfg_rd,
    input  logic [9:0]    cfg_addr,
    input  logic [31:0]   cfg_wdata,
    output logic [31:0]   cfg_rdata,
    output logic          cfg_ack,
    output logic          cfg_err,
    input  logic          frame_sync,
    output logic [2239:0] weights_m,
    output logic [151:0]  LT6p,
    output logic [151:0]  HT6p,
    output logic [151:0]  LT56p,
    output logic [151:0]  HT56p,
    output logic          trig_mask,
    output logic          cfg_busy
);

    localparam int unsigned W_BITS    = 10;
    localparam int unsigned T_BITS    = 19;
    localparam int unsigned T_MODS    = 8;
    localparam int unsigned BANK_BITS = 152;
    localparam int unsigned W_TOTAL   = 2240;
    localparam int unsigned T_TOTAL   = 608;
    localparam int unsigned CNT_W     = 8;

    localparam logic [BANK_BITS-1:0] HT_RST = {T_MODS{19'h1FFFF}};
    localparam logic [T_TOTAL-1:0]   T_RST  = {HT_RST, {BANK_BITS{1'b0}}, HT_RST, {BANK_BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        COPY    = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t             state;
    logic [15:0]        commit_count;
    logic [CNT_W-1:0]   flush_cnt;
    logic [W_TOTAL-1:0] sh_w;
    logic [T_TOTAL-1:0] sh_t;
    logic [T_TOTAL-1:0] act_t;

    logic               is_wr, is_rd, is_w, is_t, is_ctl, is_sts, tap7, lock;
    logic               wr_w_c, wr_t_c, commit_c, abort_c, err_c;
    logic [31:0]        rdata_c;
    logic [11:0]        w_idx;
    logic [9:0]         t_idx;
    logic [W_BITS-1:0]  w_rd;
    logic [T_BITS-1:0]  t_rd;
    logic               unused_wdata;

    // Address decode and shadow-slot location
    assign is_wr  = cfg_wr;
    assign is_rd  = cfg_rd;
    assign is_w   = (cfg_addr[9:8] == 2'b00);
    assign is_t   = (cfg_addr[9:5] == 5'b01000);
    assign is_ctl = (cfg_addr == 10'h200);
    assign is_sts = (cfg_addr == 10'h201);
    assign tap7   = (cfg_addr[2:0] == 3'd7);
    assign lock   = (state == PENDING) || (state == COPY);
    assign w_idx  = 12'(cfg_addr[7:3]) * 12'd70 + 12'(cfg_addr[2:0]) * 12'd10;
    assign t_idx  = 10'(cfg_addr[4:3]) * 10'd152 + 10'(cfg_addr[2:0]) * 10'd19;
    assign w_rd   = sh_w[w_idx +: W_BITS];
    assign t_rd   = sh_t[t_idx +: T_BITS];
    assign unused_wdata = ^cfg_wdata[31:19];

    // Accepted side effects of a single (non-colliding) write
    assign wr_w_c   = is_wr & ~is_rd & is_w & ~tap7 & ~lock;
    assign wr_t_c   = is_wr & ~is_rd & is_t & ~lock;
    assign commit_c = is_wr & ~is_rd & is_ctl & cfg_wdata[0] & ~cfg_wdata[1] & (state == IDLE);
    assign abort_c  = is_wr & ~is_rd & is_ctl & cfg_wdata[1] & (state == PENDING);

    // Response error and read data for the current request
    always_comb begin
        err_c   = 1'b0;
        rdata_c = '0;
        if (is_wr && is_rd) begin
            err_c = 1'b1;
        end else if (is_wr) begin
            if (is_w)        err_c = tap7 | lock;
            else if (is_t)   err_c = lock;
            else if (is_ctl) err_c = cfg_wdata[0] & ~cfg_wdata[1] & (state != IDLE);
            else             err_c = 1'b1;
        end else if (is_rd) begin
            if (is_w) begin
                err_c = tap7;
                if (!tap7) rdata_c = 32'(w_rd);
            end else if (is_t) begin
                rdata_c = {{13{t_rd[T_BITS-1]}}, t_rd};
            end else if (is_sts) begin
                rdata_c = {commit_count, 12'd0, state, (state == PENDING), (state != IDLE)};
            end else begin
                err_c = 1'b1;
            end
        end
    end

    // Bus response and shadow bank writes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_ack   <= 1'b0;
            cfg_err   <= 1'b0;
            cfg_rdata <= '0;
            sh_w      <= '0;
            sh_t      <= T_RST;
        end else begin
            cfg_ack   <= is_wr | is_rd;
            cfg_err   <= err_c;
            cfg_rdata <= rdata_c;
            if (wr_w_c) sh_w[w_idx +: W_BITS] <= cfg_wdata[W_BITS-1:0];
            if (wr_t_c) sh_t[t_idx +: T_BITS] <= cfg_wdata[T_BITS-1:0];
        end
    end

    // Commit FSM: wait for frame boundary, copy shadow to active, then flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            commit_count <= '0;
            flush_cnt    <= '0;
            weights_m    <= '0;
            act_t        <= T_RST;
            trig_mask    <= 1'b1;
            cfg_busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (commit_c) begin
                        state    <= PENDING;
                        cfg_busy <= 1'b1;
                    end
                end
                PENDING: begin
                    if (abort_c) begin
                        state    <= IDLE;
                        cfg_busy <= 1'b0;
                    end else if (frame_sync) begin
                        state     <= COPY;
                        trig_mask <= 1'b1;
                    end
                end
                COPY: begin
                    state        <= FLUSH;
                    weights_m    <= sh_w;
                    act_t        <= sh_t;
                    commit_count <= commit_count + 16'd1;
                    flush_cnt    <= CNT_W'(1);
                end
                FLUSH: begin
                    if (flush_cnt == CNT_W'(FLUSH_CYCLES)) begin
                        state     <= IDLE;
                        cfg_busy  <= 1'b0;
                        trig_mask <= 1'b0;
                    end else begin
                        flush_cnt <= flush_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Active threshold banks in address order
    assign LT6p  = act_t[0*BANK_BITS +: BANK_BITS];
    assign HT6p  = act_t[1*BANK_BITS +: BANK_BITS];
    assign LT56p = act_t[2*BANK_BITS +: BANK_BITS];
    assign HT56p = act_t[3*BANK_BITS +: BANK_BITS];

endmodule

// File: tb/tb_mpu_cfg_ctrl.sv
// Scoreboarded bench for mpu_cfg_ctrl with a timeline-based reference model.
module tb_mpu_cfg_ctrl;

    localparam int F = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cfg_wr = 1'b0, cfg_rd = 1'b0, frame_sync = 1'b0;
    logic [9:0]    cfg_addr = '0;
    logic [31:0]   cfg_wdata = '0;
    logic [31:0]   cfg_rdata;
    logic          cfg_ack, cfg_err, trig_mask, cfg_busy;
    logic [2239:0] weights_m;
    logic [151:0]  LT6p, HT6p, LT56p, HT56p;

    always #5 clk = ~clk;

    mpu_cfg_ctrl #(.FLUSH_CYCLES(F)) dut (
        .clk(clk), .rst(rst), .cfg_wr(cfg_wr), .cfg_rd(cfg_rd), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
        .frame_sync(frame_sync), .weights_m(weights_m), .LT6p(LT6p), .HT6p(HT6p),
        .LT56p(LT56p), .HT56p(HT56p), .trig_mask(trig_mask), .cfg_busy(cfg_busy)
    );

    int passed = 0;
    int total  = 0;

    typedef struct { logic err; logic [31:0] rdata; } resp_t;
    resp_t q[$];

    // Reference model: shadow/active contents plus a timeline of the last commit
    logic [9:0]  sh_w [32][7], act_w [32][7], stg_w [32][7];
    logic [18:0] sh_t [4][8],  act_t [4][8],  stg_t [4][8];
    int          m_fs;        // cycle at which frame_sync was accepted, -1 if none
    bit          pend;
    bit          init_mask;
    int          ccount;
    int          c = 0;

    function automatic void model_reset();
        for (int k = 0; k < 32; k++)
            for (int t = 0; t < 7; t++) begin
                sh_w[k][t] = '0; act_w[k][t] = '0; stg_w[k][t] = '0;
            end
        for (int b = 0; b < 4; b++)
            for (int m = 0; m < 8; m++) begin
                sh_t[b][m]  = (b % 2 == 1) ? 19'h1FFFF : 19'h0;
                act_t[b][m] = sh_t[b][m];
                stg_t[b][m] = sh_t[b][m];
            end
        m_fs = -1; pend = 0; init_mask = 1; ccount = 0;
    endfunction

    // Phase of cycle cc: 0 idle, 1 pending, 2 copy, 3 flush
    function automatic int st_of(int cc);
        if (pend) return 1;
        if (m_fs >= 0 && cc == m_fs + 1) return 2;
        if (m_fs >= 0 && cc >= m_fs + 2 && cc <= m_fs + 1 + F) return 3;
        return 0;
    endfunction

    function automatic logic [2239:0] exp_w();
        logic [2239:0] v;
        v = '0;
        for (int k = 0; k < 32; k++)
            for (int t = 0; t < 7; t++) v[k*70 + t*10 +: 10] = act_w[k][t];
        return v;
    endfunction

    function automatic logic [151:0] exp_t(int b);
        logic [151:0] v;
        v = '0;
        for (int m = 0; m < 8; m++) v[m*19 +: 19] = act_t[b][m];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s got %h exp %h (cycle %0d)", nm, got, exp, c);
    endtask

    task automatic chk_outputs(input int s);
        logic [2239:0] ew;
        logic [151:0]  et, gt;
        string         nm [4];
        nm[0] = "LT6p"; nm[1] = "HT6p"; nm[2] = "LT56p"; nm[3] = "HT56p";
        ew = exp_w();
        total++;
        if (weights_m === ew) passed++;
        else begin
            for (int k = 0; k < 32; k++)
                if (weights_m[k*70 +: 70] !== ew[k*70 +: 70]) begin
                    $display("FAIL weights_m set %0d got %h exp %h (cycle %0d)",
                             k, weights_m[k*70 +: 70], ew[k*70 +: 70], c);
                    break;
                end
        end
        for (int b = 0; b < 4; b++) begin
            et = exp_t(b);
            case (b)
                0: gt = LT6p;
                1: gt = HT6p;
                2: gt = LT56p;
                default: gt = HT56p;
            endcase
            total++;
            if (gt === et) passed++;
            else $display("FAIL %s got %h exp %h (cycle %0d)", nm[b], gt, et, c);
        end
        chk("trig_mask", 32'(trig_mask), 32'(init_mask || s >= 2));
        chk("cfg_busy",  32'(cfg_busy),  32'(s != 0));
    endtask

    function automatic resp_t model_resp(logic wr, logic rd, logic [9:0] a, logic [31:0] d, int s);
        resp_t r;
        logic [18:0] tv;
        r.err = 1'b0; r.rdata = '0;
        if (wr && rd) r.err = 1'b1;
        else if (a < 10'h100) begin
            if (a % 8 == 7) r.err = 1'b1;
            else if (wr && (s == 1 || s == 2)) r.err = 1'b1;
            else if (rd) r.rdata = 32'(sh_w[a / 8][a % 8]);
        end else if (a < 10'h120) begin
            if (wr && (s == 1 || s == 2)) r.err = 1'b1;
            else if (rd) begin
                tv = sh_t[(a - 10'h100) / 8][a % 8];
                r.rdata = tv[18] ? (32'(tv) | 32'hFFF8_0000) : 32'(tv);
            end
        end else if (a == 10'h200) begin
            if (rd) r.err = 1'b1;
            else if (d[0] && !d[1] && s != 0) r.err = 1'b1;
        end else if (a == 10'h201) begin
            if (wr) r.err = 1'b1;
            else r.rdata = (ccount % 65536) * 65536 + s * 4 + (s == 1 ? 2 : 0) + (s != 0 ? 1 : 0);
        end else r.err = 1'b1;
        return r;
    endfunction

    // One bus cycle: check outputs, drive request, advance the model across the edge
    task automatic cyc(input logic wr, input logic rd, input logic [9:0] a,
                       input logic [31:0] d, input logic fs);
        int    s;
        resp_t r;
        bit    aborted;
        @(negedge clk);
        if (m_fs >= 0 && c == m_fs + 2) begin
            act_w = stg_w; act_t = stg_t; ccount++;
        end
        if (m_fs >= 0 && c == m_fs + 2 + F) init_mask = 0;
        s = st_of(c);
        chk_outputs(s);
        cfg_wr = wr; cfg_rd = rd; cfg_addr = a; cfg_wdata = d; frame_sync = fs;
        aborted = 0;
        if (wr || rd) begin
            r = model_resp(wr, rd, a, d, s);
            q.push_back(r);
            if (wr && !rd && !r.err) begin
                if (a < 10'h100) sh_w[a / 8][a % 8] = d[9:0];
                else if (a < 10'h120) sh_t[(a - 10'h100) / 8][a % 8] = d[18:0];
                else if (a == 10'h200) begin
                    if (d[1]) begin
                        if (s == 1) begin pend = 0; aborted = 1; end
                    end else if (d[0]) pend = 1;
                end
            end
        end
        if (s == 1 && !aborted && fs) begin
            m_fs = c; stg_w = sh_w; stg_t = sh_t; pend = 0;
        end
        c++;
    endtask

    task automatic idle(input int n, input logic fs);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 10'h0, 32'h0, fs);
    endtask

    task automatic do_reset_mid();
        @(negedge clk);
        cfg_wr = 0; cfg_rd = 0; frame_sync = 0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk_outputs(0);
        chk("ack_in_reset", 32'(cfg_ack), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        c += 4;
    endtask

    // Monitor: pop and compare each completion; idle cycles must show zeros
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_ack) begin
                total++;
                if (q.size() == 0) begin
                    $display("FAIL cfg_ack unexpected err=%0b rdata=%h", cfg_err, cfg_rdata);
                end else begin
                    resp_t e;
                    e = q.pop_front();
                    if (cfg_err === e.err && cfg_rdata === e.rdata) passed++;
                    else $display("FAIL cfg_resp got err=%0b rdata=%h exp err=%0b rdata=%h",
                                  cfg_err, cfg_rdata, e.err, e.rdata);
                end
            end else begin
                total++;
                if (cfg_err === 1'b0 && cfg_rdata === 32'h0) passed++;
                else $display("FAIL idle_resp got err=%0b rdata=%h exp err=0 rdata=0", cfg_err, cfg_rdata);
            end
        end
    end

    initial begin
        logic       wr, rd, fs;
        logic [9:0] a;
        logic [31:0] d;
        int         kind, sel;

        model_reset();
        #1 rst = 1'b1;
        #2;
        chk_outputs(0);
        @(negedge clk);
        rst = 1'b0;

        cyc(0, 1, 10'h201, 0, 0);                 // status after reset
        cyc(1, 0, 10'h00A, 32'h3FF, 0);           // set 1 tap 2
        cyc(0, 1, 10'h00A, 0, 0);
        cyc(1, 0, 10'h113, 32'h7FFFF, 0);         // LT56 module 3
        cyc(0, 1, 10'h113, 0, 0);
        cyc(1, 0, 10'h007, 32'h1, 0);             // tap 7
        cyc(1, 1, 10'h00A, 32'h0, 0);             // wr+rd collision
        cyc(0, 1, 10'h00A, 0, 0);
        cyc(0, 1, 10'h0FF, 0, 0);
        cyc(1, 0, 10'h11F, 32'h4_0001, 0);
        cyc(0, 1, 10'h11F, 0, 0);
        cyc(0, 1, 10'h200, 0, 0);                 // read control
        cyc(1, 0, 10'h201, 32'h1, 0);             // write status
        cyc(1, 0, 10'h3FF, 32'h1, 0);             // unmapped

        // Pending: rejected writes, second commit, abort
        cyc(1, 0, 10'h200, 32'h1, 0);
        cyc(0, 1, 10'h201, 0, 0);
        cyc(1, 0, 10'h00A, 32'h5, 0);
        cyc(0, 1, 10'h00A, 0, 0);
        cyc(1, 0, 10'h200, 32'h1, 0);
        cyc(1, 0, 10'h200, 32'h2, 0);
        idle(4, 1'b1);
        cyc(1, 0, 10'h200, 32'h2, 0);             // abort while idle
        cyc(0, 1, 10'h201, 0, 0);

        // Commit with frame_sync five cycles later
        cyc(1, 0, 10'h200, 32'h1, 0);
        idle(4, 1'b0);
        idle(1, 1'b1);
        cyc(1, 0, 10'h200, 32'h2, 0);             // abort during copy
        idle(6, 1'b0);
        cyc(1, 0, 10'h000, 32'h2AA, 0);           // accepted during flush
        idle(F, 1'b0);
        cyc(0, 1, 10'h201, 0, 0);

        // Reset during flush, then recover
        cyc(1, 0, 10'h1F0 >> 1, 32'h1234, 0);
        cyc(1, 0, 10'h200, 32'h1, 0);
        idle(2, 1'b1);
        idle(5, 1'b0);
        do_reset_mid();
        cyc(0, 1, 10'h201, 0, 0);
        cyc(1, 0, 10'h0F6, 32'h155, 0);
        cyc(1, 0, 10'h200, 32'h3, 0);             // abort bit wins, no commit
        cyc(1, 0, 10'h200, 32'h1, 0);
        idle(3, 1'b1);
        idle(F + 3, 1'b0);
        cyc(0, 1, 10'h201, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 9);
            wr = (sel < 5) || (sel == 9);
            rd = (sel >= 5);
            d  = $urandom;
            fs = ($urandom_range(0, 3) == 0);
            case (kind)
                0, 1, 2: a = 10'($urandom_range(0, 255));
                3, 4:    a = 10'(10'h100 + $urandom_range(0, 31));
                5: begin
                    a = 10'h200; d = 32'($urandom_range(0, 3));
                    if ($urandom_range(0, 3) != 0) begin wr = 1; rd = 0; fs = 0; end
                end
                6: begin a = 10'h201; wr = ($urandom_range(0, 7) == 0); rd = 1; end
                7: a = ($urandom_range(0, 1) == 0) ? 10'($urandom_range(10'h120, 10'h1FF))
                                                   : 10'($urandom_range(10'h202, 10'h3FF));
                default: begin wr = 0; rd = 0; end
            endcase
            if (a == 10'h200 && wr && !rd) fs = 0;
            cyc(wr, rd, a, d, fs);
        end
        idle(F + 6, 1'b0);
        cyc(0, 1, 10'h201, 0, 0);
        idle(2, 1'b0);

        chk("scoreboard_empty", 32'(q.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mpu_cfg_ctrl.md
# mpu_cfg_ctrl

Configuration controller for the MPU trigger datapath. It owns the 32 FIR weight sets and the four threshold banks of 8 modules each, and loads them from a host register bus into a shadow bank. On command it copies the shadow bank into the active bank on a frame boundary, then masks trigger outputs while the cell-energy and detect pipelines settle. Its outputs drive the MPU `weights_m`, `LT6p`, `HT6p`, `LT56p` and `HT56p` inputs directly.

## Interface
- `FLUSH_CYCLES`, 16, number of cycles `trig_mask` stays high after an active-bank update (1..255).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cfg_wr` in 1: write request, one-cycle strobe.
- `cfg_rd` in 1: read request, one-cycle strobe.
- `cfg_addr` in 10: register address.
- `cfg_wdata` in 32: write data.
- `cfg_rdata` out 32: read data, valid only while `cfg_ack`=1, otherwise 0.
- `cfg_ack` out 1: one-cycle completion pulse.
- `cfg_err` out 1: qualifies `cfg_ack`; 1 means the request was rejected and had no effect.
- `frame_sync` in 1: frame boundary strobe, the only point at which a commit may apply.
- `weights_m` out 2240: active weights. Set k is at `[k*70 +: 70]`, tap t at `+ t*10`, 10 bits each.
- `LT6p`, `HT6p`, `LT56p`, `HT56p` out 152 each: active thresholds. Module m is at `[m*19 +: 19]`, signed.
- `trig_mask` out 1: 1 = downstream trigger results must be suppressed.
- `cfg_busy` out 1: 1 when the FSM is not in IDLE.

## Operation
Address map:
- 0x000–0x0FF: weight, index = set*8+tap.
  - set is 0..31; tap is 0..6.
  - tap 7 is an error.
  - Data is `cfg_wdata[9:0]`.
- 0x100–0x11F: threshold, bank = addr[4:3] (0=LT6, 1=HT6, 2=LT56, 3=HT56), module = addr[2:0].
  - Data is `cfg_wdata[18:0]`.
- 0x200: control (write only).
  - bit0 = commit.
  - bit1 = abort; it takes priority when both bits are set.
- 0x201: status (read only) = {commit_count[15:0], 12'b0, state[1:0], pending, busy}.
- Any other address, a write to 0x201 or a read of 0x200 is an error.

Register-bus rules:
- Reads of weights and thresholds return the shadow value, zero-extended for weights and sign-extended for thresholds.
- `cfg_wr` and `cfg_rd` asserted together is an error; nothing is written.
- Shadow writes are rejected (error) in PENDING and COPY. They are accepted in IDLE and FLUSH.

FSM states: IDLE, PENDING, COPY, FLUSH.
- IDLE → PENDING on an accepted commit.
- A commit while not in IDLE is an error and is ignored.
- PENDING → COPY when `frame_sync`=1.
- PENDING → IDLE on abort. Abort in any other state is acknowledged without error and has no effect.
- COPY → FLUSH after one cycle. At the exit edge, active ← shadow for all 32 weight sets and all 32 thresholds, and commit_count increments (wraps 0xFFFF→0).
- FLUSH → IDLE when the flush counter reaches FLUSH_CYCLES.

`trig_mask` behaviour:
- It is high in COPY and FLUSH.
- Out of reset it is also high, and stays high until the first FLUSH completes.
- Abort does not clear this initial mask.

Reset values:
- All shadow and active weights are 0.
- LT banks are 0; HT banks are 19'h1FFFF.
- State is IDLE, commit_count is 0.
- `cfg_ack`, `cfg_err` and `cfg_rdata` are 0; `trig_mask` is 1; `cfg_busy` is 0.

## Timing
- Request sampled at edge N → `cfg_ack`, `cfg_err` and `cfg_rdata` are valid in cycle N+1, for exactly one cycle.
- The shadow bank updates at edge N.
- Back-to-back requests every cycle are supported.
- A commit sampled at edge N puts the state in PENDING from N+1.
- `frame_sync` is only examined while in PENDING; a `frame_sync` in cycle N itself is ignored.
- `frame_sync` sampled high at edge M:
  - COPY occupies cycle M+1.
  - The active outputs show the new values from cycle M+2.
  - FLUSH occupies M+2 .. M+1+FLUSH_CYCLES.
  - `trig_mask` and `cfg_busy` are 0 from cycle M+2+FLUSH_CYCLES.
- Active outputs change only at the COPY exit edge, with all fields updating on the same edge.
- Asserting `rst` mid-operation returns everything to reset values immediately, including the active bank and any pending commit.

## Test plan
- Reset:
  - weights_m=0, HT6p = 8×19'h1FFFF, trig_mask=1.
  - Reading 0x201 gives 0x00000000.
- Write 0x3FF to 0x00A (set 1, tap 2) then read it back:
  - The ack after the read carries rdata=0x000003FF, err=0.
  - weights_m[99:90] is still 0.
- Write 0x7FFFF to 0x113 (LT56 module 3) and read it back:
  - rdata=0xFFFFFFFF.
  - Write 0x007 → err=1.
  - Simultaneous wr+rd → err=1, no change.
- Commit, then `frame_sync` 5 cycles later with FLUSH_CYCLES=16:
  - Weights and thresholds update exactly 2 cycles after `frame_sync`.
  - trig_mask falls 18 cycles after `frame_sync`.
  - commit_count=1.
- While PENDING:
  - A shadow write → err=1 and the shadow is unchanged.
  - A second commit → err.
  - Abort → IDLE; the outputs never change and trig_mask stays 1.
- Assert `rst` during FLUSH after the first commit:
  - Outputs return to reset values in the same cycle.
  - Recovery via a new commit succeeds.
